spy_uart_bridge: RTL

Serial debug front end for the CADR spy bus. It receives 8N1 command bytes on rs232_rxd and turns them into spy register reads and writes, driving eadr, dbread, dbwrite and spy data into cpu. Read results are returned over rs232_txd. It occupies the spy-port slot next to busint/cadr in lm3 and replaces the stub that ties rs232_txd low.

---
 rtl/spy_uart_pkg.sv | 25 ++
 rtl/spy_uart_phy.sv | 121 ++++++++++++
 rtl/spy_uart_bridge.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/spy_uart_pkg.sv
// Shared types and constants for the spy-bus UART bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional macro SPY_WRITE_ACK_EN adds the ACK parser state.
package spy_uart_pkg;

    // Parser states; ACK only exists when write acknowledges are built in.
    typedef enum logic [2:0] {
        IDLE,
        GET_LO,
        GET_HI,
        WRITE,
        READ,
        SEND_LO,
        SEND_HI
`ifdef SPY_WRITE_ACK_EN
        , ACK
`endif
    } state_t;

    // Command byte layout: bit7 selects write, bits 4:0 carry eadr, 6:5 ignored.
    localparam int         CMD_WRITE_BIT = 7;
    localparam int         CMD_EADR_MSB  = 4;
    localparam logic [7:0] ACK_BYTE      = 8'h06;

endpackage

// File: rtl/spy_uart_phy.sv
// 8N1 UART phy: 2-flop rx synchronizer, rx deserializer, tx serializer.
// Latency: rx_valid one cycle after mid-stop sample; tx start bit the cycle after tx_load.
// Backpressure: none on rx (one-cycle rx_valid, must be consumed); tx_load ignored while tx_busy.
// Ports: rxd/txd serial lines; rx_data/rx_valid received byte; tx_data/tx_load/tx_busy transmit side.
module spy_uart_phy #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_busy
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic              rxd_meta, rxd_s, rxd_prev;
    rx_state_t         rx_st;
    logic [BAUD_W-1:0] rx_baud;
    logic [3:0]        rx_bits;
    logic [7:0]        rx_shift;

    logic [BAUD_W-1:0] tx_baud;
    logic [3:0]        tx_bits;
    logic [7:0]        tx_shift;

    assign rx_data = rx_shift;

    // Receive side. rxd_prev gives edge detection so a held-low line after a
    // framing error cannot retrigger a frame until it has gone idle again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
            rx_st    <= RX_IDLE;
            rx_baud  <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
            rx_valid <= 1'b0;
            case (rx_st)
                RX_IDLE: begin
                    rx_baud <= '0;
                    rx_bits <= '0;
                    if (rxd_prev && !rxd_s) rx_st <= RX_START;
                end
                RX_START: begin
                    if (rx_baud == HALF_LAST) begin
                        rx_baud <= '0;
                        rx_st   <= rxd_s ? RX_IDLE : RX_DATA;  // high here = false start
                    end else begin
                        rx_baud <= rx_baud + BAUD_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_baud == BAUD_LAST) begin
                        rx_baud  <= '0;
                        rx_shift <= {rxd_s, rx_shift[7:1]};
                        if (rx_bits == 4'd7) rx_st <= RX_STOP;
                        else                 rx_bits <= rx_bits + 4'd1;
                    end else begin
                        rx_baud <= rx_baud + BAUD_W'(1);
                    end
                end
                default: begin  // RX_STOP
                    if (rx_baud == BAUD_LAST) begin
                        rx_st    <= RX_IDLE;
                        rx_valid <= rxd_s;  // stop bit of 0 drops the byte
                    end else begin
                        rx_baud <= rx_baud + BAUD_W'(1);
                    end
                end
            endcase
        end
    end

    // Transmit side. tx_bits 0 is the start bit, 1..8 data, 9 stop; the shift
    // register back-fills ones so the stop level falls out of the last shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            tx_baud  <= '0;
            tx_bits  <= '0;
            tx_shift <= '0;
        end else if (!tx_busy) begin
            if (tx_load) begin
                tx_shift <= tx_data;
                txd      <= 1'b0;
                tx_busy  <= 1'b1;
                tx_baud  <= '0;
                tx_bits  <= '0;
            end
        end else if (tx_baud == BAUD_LAST) begin
            tx_baud <= '0;
            if (tx_bits == 4'd9) begin
                tx_busy <= 1'b0;
            end else begin
                txd      <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[7:1]};
                tx_bits  <= tx_bits + 4'd1;
            end
        end else begin
            tx_baud <= tx_baud + BAUD_W'(1);
        end
    end

endmodule

// File: rtl/spy_uart_bridge.sv
// Serial debug front end: UART command bytes become CADR spy reads/writes; read data goes back on TX.
// Latency: dbwrite 1 cycle after high-byte rx_valid; dbread 1 cycle after command rx_valid.
// Backpressure: none; bytes arriving while a strobe or reply is in progress are discarded.
// Ports: rs232_rxd/rs232_txd serial; spy_in read data; spy_out/eadr/dbread/dbwrite spy bus.
// Build option: define SPY_WRITE_ACK_EN to answer every write with ACK_BYTE on TX.
module spy_uart_bridge
    import spy_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int READ_CYCLES  = 4,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rs232_rxd,
    output logic        rs232_txd,
    input  logic [15:0] spy_in,
    output logic [15:0] spy_out,
    output logic [4:0]  eadr,
    output logic        dbread,
    output logic        dbwrite
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int                TO_W      = $clog2(TIMEOUT_BITS + 1);
    localparam int                RD_W      = $clog2(READ_CYCLES + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT_BITS);
    localparam logic [RD_W-1:0]   RD_LAST   = RD_W'(READ_CYCLES - 1);

    state_t            state, state_nxt;
    logic [7:0]        rx_data, tx_data, lo_byte;
    logic              rx_valid, tx_load, tx_busy;
    logic [15:0]       hold;
    logic [RD_W-1:0]   rd_cnt;
    logic [BAUD_W-1:0] tick_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              sent;     // current SEND/ACK state has already loaded its byte
    logic              in_get;

    spy_uart_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
        .clk      (clk),
        .reset_n  (reset_n),
        .rxd      (rs232_rxd),
        .txd      (rs232_txd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_busy  (tx_busy)
    );

    assign dbread  = (state == READ);
    assign dbwrite = (state == WRITE);
    assign in_get  = (state == GET_LO) || (state == GET_HI);

    always_comb begin
        state_nxt = state;
        tx_load   = 1'b0;
        tx_data   = hold[7:0];
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data[CMD_WRITE_BIT]) state_nxt = GET_LO;
                    else                        state_nxt = READ;
                end
            end
            GET_LO: begin
                if (rx_valid)                 state_nxt = GET_HI;
                else if (to_cnt == TO_LIMIT)  state_nxt = IDLE;
            end
            GET_HI: begin
                if (rx_valid)                 state_nxt = WRITE;
                else if (to_cnt == TO_LIMIT)  state_nxt = IDLE;
            end
            WRITE: begin
`ifdef SPY_WRITE_ACK_EN
                state_nxt = ACK;
`else
                state_nxt = IDLE;
`endif
            end
            READ: begin
                if (rd_cnt == RD_LAST) state_nxt = SEND_LO;
            end
            SEND_LO: begin
                tx_data = hold[7:0];
                if (!sent)         tx_load   = !tx_busy;
                else if (!tx_busy) state_nxt = SEND_HI;
            end
            SEND_HI: begin
                tx_data = hold[15:8];
                if (!sent)         tx_load   = !tx_busy;
                else if (!tx_busy) state_nxt = IDLE;
            end
`ifdef SPY_WRITE_ACK_EN
            ACK: begin
                tx_data = ACK_BYTE;
                if (!sent)         tx_load   = !tx_busy;
                else if (!tx_busy) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            eadr     <= '0;
            spy_out  <= '0;
            lo_byte  <= '0;
            hold     <= '0;
            rd_cnt   <= '0;
            sent     <= 1'b0;
            tick_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            state <= state_nxt;
            sent  <= (state_nxt == state) ? (sent | tx_load) : 1'b0;

            if (state == IDLE   && rx_valid) eadr    <= rx_data[CMD_EADR_MSB:0];
            if (state == GET_LO && rx_valid) lo_byte <= rx_data;
            if (state == GET_HI && rx_valid) spy_out <= {rx_data, lo_byte};

            // Read window: capture spy_in on the last dbread cycle.
            if (state == READ) begin
                if (rd_cnt == RD_LAST) begin
                    hold   <= spy_in;
                    rd_cnt <= '0;
                end else begin
                    rd_cnt <= rd_cnt + RD_W'(1);
                end
            end else begin
                rd_cnt <= '0;
            end

            // Mid-command idle timer in whole bit-times; saturates at the limit.
            if (!in_get || rx_valid) begin
                tick_cnt <= '0;
                to_cnt   <= '0;
            end else if (tick_cnt == BAUD_LAST) begin
                tick_cnt <= '0;
                if (to_cnt != TO_LIMIT) to_cnt <= to_cnt + TO_W'(1);
            end else begin
                tick_cnt <= tick_cnt + BAUD_W'(1);
            end
        end
    end

endmodule
